// File: rtl/multi_shift_register.sv
// -----------------------------------------------------------------------------
// multi_shift_register
//
// Serial multi-bit shifter for the multiplier datapath. A WIDTH-bit operand is
// loaded on an accepted start and then shifted one bit per clock, left or
// right, for a run-time number of steps. Arithmetic, logical and rotate modes
// are supported. The start/busy/done handshake lets a controlling FSM issue a
// whole multi-bit shift as one request.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//   AMT_W      width of the shift-amount input (amounts 0 .. 2^AMT_W-1)
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   start      request; only sampled while idle or done
//   in         operand, captured on an accepted start
//   amount     shift count, captured on an accepted start
//   dir        0 = right, 1 = left; captured on an accepted start
//   mode       00 arithmetic, 01 logical, 10 rotate, 11 logical
//   out        working / result register
//   shift_out  last bit shifted or rotated out (0 when amount = 0)
//   busy       high while shifting
//   done       one-cycle pulse, result valid
// -----------------------------------------------------------------------------
module multi_shift_register #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    // -------------------------------------------------------------------------
    // Types
    // -------------------------------------------------------------------------
    // Encoding chosen so busy/done each depend on a single state bit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_ARITH     = 2'b00,
        MODE_LOGIC     = 2'b01,
        MODE_ROTATE    = 2'b10,
        MODE_LOGIC_ALT = 2'b11
    } mode_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             shift_out_q, shift_out_d;
    logic [AMT_W-1:0] count_q,     count_d;
    logic             dir_q,       dir_d;
    mode_t            mode_q,      mode_d;

    // -------------------------------------------------------------------------
    // Control decodes
    // -------------------------------------------------------------------------
    logic accepting;
    logic accept;
    logic last_step;

    assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = accepting && start;
    assign last_step = (count_q == AMT_W'(1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A zero amount skips SHIFT and reports done straight away.
                    state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (pure decodes of the registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single-step shifter
    // -------------------------------------------------------------------------
    logic             fill_msb;
    logic             fill_lsb;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    // Bit entering the vacated end of the word for one step.
    always_comb begin
        fill_msb = 1'b0;
        fill_lsb = 1'b0;
        unique case (mode_q)
            MODE_ARITH: begin
                fill_msb = out_q[WIDTH-1];
                fill_lsb = 1'b0;
            end
            MODE_ROTATE: begin
                fill_msb = out_q[0];
                fill_lsb = out_q[WIDTH-1];
            end
            default: begin
                fill_msb = 1'b0;
                fill_lsb = 1'b0;
            end
        endcase
    end

    always_comb begin
        step_val = out_q;
        step_bit = 1'b0;
        if (dir_q) begin
            step_val = {out_q[WIDTH-2:0], fill_lsb};
            step_bit = out_q[WIDTH-1];
        end else begin
            step_val = {fill_msb, out_q[WIDTH-1:1]};
            step_bit = out_q[0];
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        out_d       = out_q;
        shift_out_d = shift_out_q;
        count_d     = count_q;
        dir_d       = dir_q;
        mode_d      = mode_q;
        if (accept) begin
            out_d       = in;
            shift_out_d = 1'b0;
            count_d     = amount;
            dir_d       = dir;
            mode_d      = mode_t'(mode);
        end else if (state_q == ST_SHIFT) begin
            // start is deliberately ignored here: operands stay latched.
            out_d       = step_val;
            shift_out_d = step_bit;
            count_d     = count_q - AMT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            shift_out_q <= 1'b0;
            count_q     <= '0;
            dir_q       <= 1'b0;
            mode_q      <= MODE_ARITH;
        end else begin
            out_q       <= out_d;
            shift_out_q <= shift_out_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
        end
    end

    assign out       = out_q;
    assign shift_out = shift_out_q;

endmodule

// File: doc/multi_shift_register.md
Name: multi_shift_register

Overview:
Parametrised serial shifter, the successor to the single-step right shift register used by the multiplier datapath. It loads a WIDTH-bit operand and shifts it by a run-time amount, one bit per clock, in either direction. Modes are arithmetic, logical and rotate. A start/busy/done handshake lets the multiplier control FSM hand off multi-bit shifts instead of sequencing single shifts itself.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)
AMT_W, 4, width of shift-amount input; amounts 0 .. 2^AMT_W-1 accepted

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when accepting (IDLE or DONE)
in  input  WIDTH  operand, captured on accepted start
amount  input  AMT_W  shift count, captured on accepted start
dir  input  1  0 = right, 1 = left; captured on accepted start
mode  input  2  00 arithmetic, 01 logical, 10 rotate, 11 treated as logical; captured on accepted start
out  output  WIDTH  working/result register
shift_out  output  1  last bit shifted/rotated out of out; 0 if amount = 0
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, result valid

Behaviour:
- Single clock domain; reset is asynchronous and active-high; clock port clk, reset port reset.
- Reset (async assert, any state): state=IDLE, out=0, shift_out=0, busy=0, done=0, count=0.
- FSM states: IDLE, SHIFT, DONE.
- Accepting states: IDLE and DONE. A start in DONE is accepted, so back-to-back operations are allowed.
- Accepted start (edge E0): out<=in, shift_out<=0, count<=amount, dir/mode latched. Next state is SHIFT if amount != 0, else DONE.
- SHIFT, each edge:
  - perform one 1-bit step and decrement count.
  - when count==1 on that edge, next state is DONE; otherwise stay in SHIFT.
- Latency: for amount k>=1, edges E1..Ek shift and done is high in the cycle after Ek. For k=0, done is high in the cycle after E0.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or a new load if start=1.
- Right step:
  - out[WIDTH-2:0]<=out[WIDTH-1:1] and shift_out<=out[0].
  - MSB fill: out[WIDTH-1] (arithmetic), 0 (logical), out[0] (rotate).
- Left step:
  - out[WIDTH-1:1]<=out[WIDTH-2:0] and shift_out<=out[WIDTH-1].
  - LSB fill: 0 (arithmetic and logical), out[WIDTH-1] (rotate).
- Amounts >= WIDTH are legal and keep shifting serially:
  - logical: result 0.
  - arithmetic right: all sign bits.
  - rotate: wraps modulo WIDTH.
- start while in SHIFT: ignored. Latched operands and count are unaffected, and no queueing occurs.
- Inputs in/amount/dir/mode may change freely after the accepted edge.
- out and shift_out hold their values in IDLE until the next accepted start.
- busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes, glitch-free.
- reset asserted mid-SHIFT: immediate return to the reset values; the partial result is discarded.

Test Plan:
- WIDTH=16. in=0x8001, amount=3, dir=0, mode=00 -> out sequence 0xC000, 0xE000, 0xF000. done in the cycle after the 3rd shift edge, busy high for 3 cycles, shift_out=0.
- in=0x8001, amount=1, dir=0, mode=01 -> out=0x4000, shift_out=1, done one cycle after the shift edge. Then immediately start in=0x0001, amount=15, dir=1, mode=01 from DONE -> accepted, out=0x8000 after 15 shifts, shift_out=0.
- in=0x8001, amount=4, dir=1, mode=10 -> out 0x0003, 0x0006, 0x000C, 0x0018, shift_out=0. Repeat with amount=15 (rotate wrap) -> out=0xC000.
- amount=0, in=0x1234, any mode -> no busy cycle, done in the cycle after the load edge, out=0x1234, shift_out=0.
- Arithmetic right, in=0x8000, amount=15 -> out=0xFFFF, shift_out=0. Assert start with in=0x0000 during SHIFT -> ignored, result unchanged.
- Start in=0xFFFF, amount=10; assert reset asynchronously after the 4th shift edge -> out=0, busy=0, done=0 immediately. After reset release, a new start completes normally.
